// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word CPU accesses mapped onto a 32-bit word memory, sub-word stores via read-modify-write.
// Latency accept->done: load 2, word store 2, sub-word store 3, error 1 cycle (alignment errors only with LSU_ALIGN_CHECK_EN).
// Backpressure: ready is high only in IDLE; req is ignored while an access is in flight or completing.
module load_store_unit #(
    parameter int ADR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [1:0]       size,
    input  logic             sgn,
    input  logic [ADR_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic             ready,
    output logic             done,
    output logic             err,
    output logic [31:0]      rdata,
    output logic [ADR_W-1:0] adr,
    output logic             mrd,
    output logic             mwr,
    output logic [31:0]      d_in,
    input  logic [31:0]      d_out
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t             state_q, state_d;
    logic               we_q, word_q, half_q, sgn_q, err_q;
    logic [1:0]         lane_q;
    logic [ADR_W-3:0]   base_q;
    logic [31:0]        wdata_q, cap_q, rdata_q;
    logic               bad;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        load_val, merged;

`ifdef LSU_ALIGN_CHECK_EN
    assign bad = (size == 2'b11) ||
                 (size == 2'b01 && addr[0]) ||
                 (size == 2'b10 && addr[1:0] != 2'b00);
`else
    assign bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req) begin
                if (bad)                state_d = DONE;
                else if (we && size[1]) state_d = WR;
                else                    state_d = RD;
            end
            RD:      state_d = we_q ? WR : DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_sel = d_out[7:0];
        case (lane_q)
            2'd1:    byte_sel = d_out[15:8];
            2'd2:    byte_sel = d_out[23:16];
            2'd3:    byte_sel = d_out[31:24];
            default: byte_sel = d_out[7:0];
        endcase
        half_sel = lane_q[1] ? d_out[31:16] : d_out[15:0];
        if (word_q)
            load_val = d_out;
        else if (half_q)
            load_val = {{16{sgn_q & half_sel[15]}}, half_sel};
        else
            load_val = {{24{sgn_q & byte_sel[7]}}, byte_sel};
    end

    // Read-modify-write: replace only the addressed lane(s) of the captured word.
    always_comb begin
        merged = cap_q;
        if (half_q) begin
            if (lane_q[1]) merged[31:16] = wdata_q[15:0];
            else           merged[15:0]  = wdata_q[15:0];
        end else begin
            case (lane_q)
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                2'd3:    merged[31:24] = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            word_q  <= 1'b0;
            half_q  <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            lane_q  <= 2'b00;
            base_q  <= '0;
            wdata_q <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                we_q    <= we;
                word_q  <= size[1];
                half_q  <= (size == 2'b01);
                sgn_q   <= sgn;
                err_q   <= bad;
                lane_q  <= addr[1:0];
                base_q  <= addr[ADR_W-1:2];
                wdata_q <= wdata;
            end
            if (state_q == RD) begin
                if (we_q) cap_q   <= d_out;
                else      rdata_q <= load_val;
            end
        end
    end

    // Strobes come straight from state so an async reset kills them immediately.
    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign err   = (state_q == DONE) & err_q;
    assign mrd   = (state_q == RD);
    assign mwr   = (state_q == WR);
    assign adr   = {base_q, 2'b00};
    assign d_in  = (state_q == WR) ? (word_q ? wdata_q : merged) : 32'h0;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-memory model and an expected-result queue.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we, sgn;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        ready, done, err, mrd, mwr;
    logic [31:0] rdata, adr, d_in, d_out;

    typedef struct packed {
        logic [31:0] rd;
        logic        er;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [0:255];
    int          compared   = 0;
    int          mismatched = 0;
    int          rd_cnt, wr_cnt, cyc = 0;
    logic [31:0] last_din;

    load_store_unit #(.ADR_W(32)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sgn(sgn),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
        .rdata(rdata), .adr(adr), .mrd(mrd), .mwr(mwr), .d_in(d_in), .d_out(d_out)
    );

    always #5 clk = ~clk;

    assign d_out = mem[adr[9:2]];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mwr) mem[adr[9:2]] = d_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard pop on every completion pulse, plus strobe bookkeeping.
    always @(negedge clk) begin
        if (mrd) rd_cnt++;
        if (mwr) begin
            wr_cnt++;
            last_din = d_in;
        end else begin
            chk("d_in_idle_zero", d_in, 32'h0);
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rdata", rdata, e.rd);
                chk("err", {31'd0, err}, {31'd0, e.er});
            end
        end
    end

    task automatic access(input logic w, input logic [1:0] sz, input logic s,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input int exp_rdc, input int exp_wrc);
        int lat;
        exp_q.push_back(exp_t'{rd: exp_rd, er: exp_err});
        rd_cnt = 0;
        wr_cnt = 0;
        req = 1'b1; we = w; size = sz; sgn = s; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        chk("latency", lat, exp_lat);
        @(posedge clk);
        #1;
        chk("mrd_cycles", rd_cnt, exp_rdc);
        chk("mwr_cycles", wr_cnt, exp_wrc);
        chk("ready_after", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int c1;
        bit got;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[26] = 32'd1;           // 104
        mem[27] = 32'd2;           // 108
        mem[28] = 32'd3;           // 112
        mem[50] = 32'hAAAA5555;    // 200
        req = 0; we = 0; size = 0; sgn = 0; addr = 0; wdata = 0;
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_err",   {31'd0, err},   32'd0);
        chk("rst_mrd",   {31'd0, mrd},   32'd0);
        chk("rst_mwr",   {31'd0, mwr},   32'd0);
        chk("rst_d_in",  d_in,  32'h0);
        chk("rst_rdata", rdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        access(0, 2'b10, 0, 32'd104, 32'h0, 32'h00000001, 0, 2, 1, 0);
        access(1, 2'b00, 0, 32'd109, 32'h00000080, 32'h00000001, 0, 3, 1, 1);
        chk("sb_d_in", last_din, 32'h00008002);
        chk("sb_mem", mem[27], 32'h00008002);
        access(0, 2'b00, 1, 32'd109, 32'h0, 32'hFFFFFF80, 0, 2, 1, 0);
        access(0, 2'b00, 0, 32'd109, 32'h0, 32'h00000080, 0, 2, 1, 0);
        access(1, 2'b01, 0, 32'd114, 32'h0000BEEF, 32'h00000080, 0, 3, 1, 1);
        chk("sh_d_in", last_din, 32'hBEEF0003);
        access(0, 2'b10, 0, 32'd112, 32'h0, 32'hBEEF0003, 0, 2, 1, 0);
        access(0, 2'b01, 1, 32'd114, 32'h0, 32'hFFFFBEEF, 0, 2, 1, 0);
        access(0, 2'b00, 0, 32'd115, 32'h0, 32'h000000BE, 0, 2, 1, 0);
`ifdef LSU_ALIGN_CHECK_EN
        access(0, 2'b10, 0, 32'd102, 32'h0, 32'h000000BE, 1, 1, 0, 0);
        access(1, 2'b11, 0, 32'd104, 32'hFFFFFFFF, 32'h000000BE, 1, 1, 0, 0);
        chk("err_no_write", mem[26], 32'h00000001);
`else
        access(0, 2'b10, 0, 32'd102, 32'h0, 32'h00000000, 0, 2, 1, 0);
`endif
        access(1, 2'b10, 0, 32'd204, 32'h0BADF00D, rdata, 0, 2, 0, 1);
        chk("sw_d_in", last_din, 32'h0BADF00D);
        access(0, 2'b10, 1, 32'd204, 32'h0, 32'h0BADF00D, 0, 2, 1, 0);

        // Back-to-back: req held high across DONE, second access starts in the next IDLE.
        exp_q.push_back(exp_t'{rd: 32'h00000001, er: 1'b0});
        exp_q.push_back(exp_t'{rd: 32'h00000001, er: 1'b0});
        req = 1'b1; we = 1'b0; size = 2'b10; sgn = 1'b0; addr = 32'd104;
        got = 0;
        c1 = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (done) begin got = 1; c1 = cyc; end
        end
        chk("b2b_first_done", {31'd0, got}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_ready_idle", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1 req = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        chk("b2b_gap", cyc - c1, 32'd3);
        @(posedge clk);
        #1;

        // Reset mid-WR must abort the word store before any edge can commit it.
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'd200; wdata = 32'h12345678;
        @(posedge clk);
        #2 req = 1'b0;
        chk("wr_mwr_high", {31'd0, mwr}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_mwr", {31'd0, mwr}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_d_in", d_in, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_mem", mem[50], 32'hAAAA5555);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADR_W, 32, address width of CPU request and memory port.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req  input  1  CPU access request; sampled only while ready=1.
REQ-005 we  input  1  1=store, 0=load.
REQ-006 size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 sgn  input  1  1=sign-extend sub-word load, 0=zero-extend.
REQ-008 addr  input  ADR_W  byte address, little-endian (lane 0 = addr bits [1:0]=00).
REQ-009 wdata  input  32  store data, right-justified.
REQ-010 ready  output  1  high only in IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  alignment/size error, valid with done.
REQ-013 rdata  output  32  load result (memory data register), held until the next completing load.
REQ-014 adr  output  ADR_W  word-aligned address to data memory ({addr[ADR_W-1:2],2'b00}).
REQ-015 mrd, mwr  output  1 each  data-memory read/write strobes.
REQ-016 d_in  output  32  write word to data memory.
REQ-017 d_out  input  32  combinational read word from data memory.

Function
REQ-018 FSM states IDLE, RD, WR, DONE; request fields latched on the accepting edge (IDLE & req).
REQ-019 IDLE->RD for loads and byte/half stores; IDLE->WR for word stores; IDLE->DONE on error.
REQ-020 RD: mrd=1, adr=latched base; d_out captured at end of cycle; load -> DONE, store -> WR.
REQ-021 WR: mwr=1, d_in = captured word with addressed lane(s) replaced by wdata low byte/half; word store d_in=wdata; WR->DONE.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE; req during DONE ignored.
REQ-023 mrd/mwr decoded from state only; mwr never asserted outside WR, mrd never outside RD; d_in=0 outside WR.
REQ-024 Latency accept-edge to done-high cycle: load 2, word store 2, sub-word store 3, error 1 cycle.
REQ-025 Load extraction: byte lane = addr[1:0], half lane = addr[1]; extended per sgn to 32 bits; word loads ignore sgn.
REQ-026 rdata updated only in the RD->DONE transition of a load; stores and errors leave rdata unchanged.
REQ-027 Back-to-back: req high continuously starts a new access on the first IDLE cycle after DONE.

Reset
REQ-028 rst low forces state IDLE immediately, regardless of clk: ready=1, done=0, err=0, mrd=0, mwr=0, d_in=0, rdata=0.
REQ-029 Reset during WR aborts the write before the next clock edge; no partial memory update.

Configuration
REQ-030 Macro LSU_ALIGN_CHECK_EN defined: halfword with addr[0]=1, word with addr[1:0]!=00, or size=11 -> no memory strobe, done with err=1.
REQ-031 Macro undefined: err tied 0; misaligned low address bits ignored (half uses addr[1], word uses lane 0); size=11 treated as word.

Verification
REQ-032 Word at 104 = 1; load word addr 104 -> mrd one cycle, done 2 cycles after accept, rdata=0x00000001.
REQ-033 Word at 108 = 2; store byte 0x80 to 109 -> RD then WR with d_in=0x00008002; load byte sgn=1 at 109 -> rdata=0xFFFFFF80; sgn=0 -> 0x00000080.
REQ-034 Word at 112 = 3; store half 0xBEEF to 114 -> d_in=0xBEEF0003; load word 112 -> 0xBEEF0003.
REQ-035 With LSU_ALIGN_CHECK_EN, load word addr 102 -> err=1 with done one cycle after accept, mrd/mwr never high, rdata unchanged; without macro -> reads base 100, rdata=0x00000000.
REQ-036 Store word 0x12345678 to 200, assert rst low mid-WR before clock edge -> mwr drops immediately, word at 200 unchanged, ready=1.
